// File: rtl/ram_arbiter_2req.sv
// Two-requester arbiter for one single-port register-file RAM; IDLE/ACCESS/RESP sequencing.
// Define RAM_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module ram_arbiter_2req #(
  parameter int AW = 1,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic [1:0]    dbgState
);

  // Handshake: a requester holds reqN with stable we/addr/wdata until gntN pulses; the arbiter
  // samples requests only on edges leaving IDLE or RESP, so the cycle after gnt is free to drop
  // or replace the request. Read data arrives with a one-cycle rvalidN pulse the cycle after gnt.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state;
  logic          sel;
  logic          cmdWe;
  logic          winner;
  logic          tieWinner;
  logic          winWe;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winWdata;

`ifdef RAM_ARB_RR_EN
  logic last;
  assign tieWinner = ~last;
`else
  assign tieWinner = 1'b0;
`endif

  // Only feeds register loads at IDLE/RESP edges; no RAM port sees req combinationally.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = tieWinner;
    end else if (req1) begin
      winner = 1'b1;
    end
    winWe    = winner ? we1 : we0;
    winAddr  = winner ? addr1 : addr0;
    winWdata = winner ? wdata1 : wdata0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= 1'b0;
      cmdWe     <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata     <= '0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
`ifdef RAM_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_we  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (req0 || req1) begin
            state     <= ACCESS;
            sel       <= winner;
            cmdWe     <= winWe;
            ram_we    <= winWe;
            ram_addr  <= winAddr;
            ram_wdata <= winWdata;
            gnt0      <= ~winner;
            gnt1      <= winner;
            busy      <= 1'b1;
`ifdef RAM_ARB_RR_EN
            last      <= winner;
`endif
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ACCESS: begin
          state <= RESP;
          busy  <= 1'b1;
          // ram_rdata reflects ram_addr, which has been stable for the whole ACCESS cycle.
          if (!cmdWe) begin
            rdata   <= ram_rdata;
            rvalid0 <= ~sel;
            rvalid1 <= sel;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbgState = state;

  gntMutex: assert property (@(posedge clk) disable iff (!rst_n) !(gnt0 && gnt1));
  weOnlyInAccess: assert property (@(posedge clk) disable iff (!rst_n) ram_we |-> (state == ACCESS));

endmodule

// File: tb/tb_ram_arbiter_2req.sv
// Randomized and directed bench for ram_arbiter_2req against a transaction-level reference model.
module tb_ram_arbiter_2req;
  localparam int AW   = 1;
  localparam int DW   = 4;
  localparam int NW   = 2 ** AW;
  localparam int MAXC = 4096;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [AW-1:0] addr [2] = '{default: '0};
  logic [DW-1:0] wdata [2] = '{default: '0};
  logic          gnt0, gnt1, rvalid0, rvalid1, ram_we, busy;
  logic [DW-1:0] rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbgState;

  ram_arbiter_2req #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .dbgState(dbgState)
  );

  // RAM array behind the arbiter
  logic [DW-1:0] ram [NW] = '{default: '0};
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  // ---------------- scoreboard state ----------------
  int nTests = 0;
  int nFail = 0;
  int cyc = 0;

  logic [1:0]    expGnt  [MAXC] = '{default: '0};
  logic [1:0]    expRv   [MAXC] = '{default: '0};
  logic          expWe   [MAXC] = '{default: '0};
  logic          expBusy [MAXC] = '{default: '0};
  logic [AW-1:0] expAddr [MAXC] = '{default: '0};
  logic [DW-1:0] expWd   [MAXC] = '{default: '0};
  logic [DW-1:0] expData [MAXC] = '{default: '0};
  logic [DW-1:0] exp_q [$];

  logic [DW-1:0] modelMem [NW] = '{default: '0};
  logic [DW-1:0] modelRdata = '0;
  int            lastAccept = -10;
  logic          lastWinner = 1'b1;
  int            wrCommit = -1;
  logic [AW-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;

  cmd_t       q0 [$];
  cmd_t       q1 [$];
  logic [1:0] active = '0;
  logic [1:0] sawGnt = '0;
  int         gapPct = 0;

  int            gLog [$];
  int            gCyc [$];
  logic [DW-1:0] rv0Data = '0;
  logic [DW-1:0] rv1Data = '0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    nTests++;
    if (got !== expv) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic pushCmd(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_t c;
    c.we = w;
    c.addr = a;
    c.wdata = d;
    if (i == 0) q0.push_back(c);
    else q1.push_back(c);
  endtask

  function automatic int qSize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic present(input int i);
    cmd_t c;
    if (i == 0) c = q0.pop_front();
    else c = q1.pop_front();
    req[i]   = 1'b1;
    we[i]    = c.we;
    addr[i]  = c.addr;
    wdata[i] = c.wdata;
    active[i] = 1'b1;
  endtask

  // Requesters hold until granted, then either drop or present their next command.
  task automatic driveReqs();
    for (int i = 0; i < 2; i++) begin
      if (active[i] && !sawGnt[i]) continue;
      if (qSize(i) > 0 && $urandom_range(99) >= gapPct) begin
        present(i);
      end else begin
        req[i]    = 1'b0;
        active[i] = 1'b0;
        we[i]     = 1'($urandom);
        addr[i]   = AW'($urandom);
        wdata[i]  = DW'($urandom);
      end
    end
    sawGnt = '0;
  endtask

  // ---------------- reference model ----------------
  // Accesses are accepted at most every second edge; read data is the memory image at acceptance.
  task automatic modelStep();
    logic w;
    logic tie;
    if (wrCommit == cyc) begin
      modelMem[wrAddr] = wrData;
      wrCommit = -1;
    end
    if (rst_n && cyc >= lastAccept + 2 && req != 2'b00) begin
`ifdef RAM_ARB_RR_EN
      tie = ~lastWinner;
`else
      tie = 1'b0;
`endif
      w = (req == 2'b11) ? tie : req[1];
      expGnt[cyc]      = w ? 2'b10 : 2'b01;
      expBusy[cyc]     = 1'b1;
      expBusy[cyc + 1] = 1'b1;
      expWe[cyc]       = we[w];
      expAddr[cyc]     = addr[w];
      expWd[cyc]       = wdata[w];
      if (we[w]) begin
        wrCommit = cyc + 1;
        wrAddr   = addr[w];
        wrData   = wdata[w];
      end else begin
        expRv[cyc + 1]   = w ? 2'b10 : 2'b01;
        expData[cyc + 1] = modelMem[addr[w]];
      end
      lastAccept = cyc;
      lastWinner = w;
    end
  endtask

  task automatic modelReset();
    for (int k = cyc + 1; k < cyc + 3; k++) begin
      expGnt[k] = '0;
      expRv[k] = '0;
      expWe[k] = 1'b0;
      expBusy[k] = 1'b0;
    end
    wrCommit = -1;
    modelRdata = '0;
    lastAccept = -10;
    lastWinner = 1'b1;
    exp_q.delete();
    q0.delete();
    q1.delete();
    active = '0;
    sawGnt = '0;
    req = '0;
  endtask

  task automatic checkCycle();
    logic [1:0] expState;
    if (expRv[cyc] != 2'b00) begin
      modelRdata = expData[cyc];
      exp_q.push_back(expData[cyc]);
    end
    expState = (expGnt[cyc] != 2'b00) ? 2'd1 : (expBusy[cyc] ? 2'd2 : 2'd0);
    checkEq("ctl", 32'({gnt1, gnt0, rvalid1, rvalid0, ram_we, busy}),
            32'({expGnt[cyc], expRv[cyc], expWe[cyc], expBusy[cyc]}));
    checkEq("state", 32'(dbgState), 32'(expState));
    checkEq("rdata", 32'(rdata), 32'(modelRdata));
    if (expGnt[cyc] != 2'b00) begin
      checkEq("ram_addr", 32'(ram_addr), 32'(expAddr[cyc]));
      if (expWe[cyc]) checkEq("ram_wdata", 32'(ram_wdata), 32'(expWd[cyc]));
    end
    if ((rvalid0 || rvalid1) && exp_q.size() > 0) begin
      checkEq("rv_data", 32'(rdata), 32'(exp_q.pop_front()));
    end
    if (rvalid0) rv0Data = rdata;
    if (rvalid1) rv1Data = rdata;
    if (gnt0) begin gLog.push_back(0); gCyc.push_back(cyc); end
    if (gnt1) begin gLog.push_back(1); gCyc.push_back(cyc); end
    sawGnt = sawGnt | {gnt1, gnt0};
  endtask

  task automatic runCycle();
    @(posedge clk);
    cyc++;
    modelStep();
    #1;
    driveReqs();
    @(negedge clk);
    checkCycle();
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || active != 2'b00 || cyc <= lastAccept + 1) && n < limit) begin
      runCycle();
      n++;
    end
    checkEq("drain_timeout", 32'(n < limit), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  gBase;
    logic hit;
    int  expSeq [4];

    // reset values
    repeat (2) runCycle();
    checkEq("rst_outs", 32'({gnt1, gnt0, rvalid1, rvalid0, ram_we, busy, dbgState}), 32'd0);
    checkEq("rst_ram", 32'({ram_addr, ram_wdata, rdata}), 32'd0);
    rst_n = 1'b1;
    runCycle();

    // write then read, one requester
    gBase = gLog.size();
    pushCmd(0, 1'b1, AW'(1), 4'hA);
    drain(50);
    pushCmd(0, 1'b0, AW'(1), 4'h0);
    drain(50);
    checkEq("t1_rdata", 32'(rdata), 32'h0A);
    checkEq("t1_rv0", 32'(rv0Data), 32'h0A);
    checkEq("t1_gnts", 32'(gLog.size() - gBase), 32'd2);

    // idle hold
    repeat (10) runCycle();
    checkEq("t5_idle", 32'({busy, ram_we}), 32'd0);
    checkEq("t5_rdata", 32'(rdata), 32'h0A);

    // isolation between requesters
    pushCmd(0, 1'b1, AW'(0), 4'h3);
    pushCmd(1, 1'b1, AW'(1), 4'hC);
    drain(50);
    pushCmd(0, 1'b0, AW'(0), 4'h0);
    pushCmd(1, 1'b0, AW'(1), 4'h0);
    drain(50);
    checkEq("t3_rd0", 32'(rv0Data), 32'h3);
    checkEq("t3_rd1", 32'(rv1Data), 32'hC);

    // reset during ACCESS
    pushCmd(1, 1'b1, AW'(0), 4'h5);
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      runCycle();
      hit = (expGnt[cyc] != 2'b00);
    end
    checkEq("t4_reach", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    checkEq("t4_async", 32'({gnt1, gnt0, rvalid1, rvalid0, ram_we, busy, dbgState}), 32'd0);
    checkEq("t4_rdata", 32'(rdata), 32'd0);
    modelReset();
    repeat (2) runCycle();
    rst_n = 1'b1;
    gBase = gLog.size();
    pushCmd(0, 1'b0, AW'(0), 4'h0);
    pushCmd(1, 1'b0, AW'(1), 4'h0);
    drain(50);
    checkEq("t4_cnt", 32'(gLog.size() - gBase), 32'd2);
    if (gLog.size() > gBase) checkEq("t4_first_tie", 32'(gLog[gBase]), 32'd0);
    checkEq("t4_lost_write", 32'(rv0Data), 32'h3);

    // simultaneous requests held for several accesses
`ifdef RAM_ARB_RR_EN
    expSeq = '{0, 1, 0, 1};
`else
    expSeq = '{0, 0, 0, 0};
`endif
    gBase = gLog.size();
    for (int k = 0; k < 4; k++) begin
      pushCmd(0, 1'b0, AW'($urandom_range(NW - 1)), 4'h0);
      pushCmd(1, 1'b0, AW'($urandom_range(NW - 1)), 4'h0);
    end
    drain(100);
    checkEq("t2_cnt", 32'(gLog.size() - gBase), 32'd8);
    if (gLog.size() >= gBase + 4) begin
      for (int k = 0; k < 4; k++) checkEq("t2_order", 32'(gLog[gBase + k]), 32'(expSeq[k]));
      checkEq("t2_gap", 32'(gCyc[gBase + 1] - gCyc[gBase]), 32'd2);
    end

    // randomized traffic
    gapPct = 40;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(2) == 0 && q0.size() < 3)
        pushCmd(0, 1'($urandom), AW'($urandom_range(NW - 1)), DW'($urandom));
      if ($urandom_range(2) == 0 && q1.size() < 3)
        pushCmd(1, 1'($urandom), AW'($urandom_range(NW - 1)), DW'($urandom));
      runCycle();
    end
    gapPct = 0;
    drain(100);
    checkEq("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
